idma_axi_wr_slave: RTL and testbench

AXI3-style write-channel responder that terminates the write bursts issued by the iDMA write channel: 4-bit `awlen`, `wid`, 2-bit `awlock`, 256-bit data. It queues AW commands and converts W beats into single-cycle writes on a local SRAM-style port. It returns one B response per burst with the matching ID. It is the memory-side endpoint for iDMA loopback and subsystem-local buffers.

---
 rtl/idma_axi_wr_slave.sv | 175 +++++++++++++++++
 tb/tb_idma_axi_wr_slave.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/idma_axi_wr_slave.sv
// idma_axi_wr_slave: AXI3 write-burst responder terminating iDMA writes on a local SRAM port
module idma_axi_wr_slave #(
  parameter int AXI_DATA_WID = 256,
  parameter int AXI_ADDR_WID = 32,
  parameter int AXI_IDW      = 4,
  parameter int AXI_LENW     = 4,
  parameter int AXI_STRBW    = AXI_DATA_WID / 8,
  parameter int MEM_AW       = 12,
  parameter int CMD_DEPTH    = 4,
  parameter int BRSP_DEPTH   = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [AXI_IDW-1:0]      i_awid,
  input  logic [AXI_ADDR_WID-1:0] i_awaddr,
  input  logic [AXI_LENW-1:0]     i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic [1:0]              i_awlock,
  input  logic [3:0]              i_awcache,
  input  logic [2:0]              i_awprot,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  input  logic [AXI_IDW-1:0]      i_wid,
  input  logic                    i_wlast,
  input  logic [AXI_DATA_WID-1:0] i_wdata,
  input  logic [AXI_STRBW-1:0]    i_wstrb,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [AXI_IDW-1:0]      o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_mem_we,
  output logic [MEM_AW-1:0]       o_mem_addr,
  output logic [AXI_DATA_WID-1:0] o_mem_wdata,
  output logic [AXI_STRBW-1:0]    o_mem_wstrb,
  output logic                    o_idle,
  output logic [7:0]              o_err_cnt
);
  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int BPW = $clog2(BRSP_DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_DRAIN} w_state_e;
  typedef struct packed {
    logic [AXI_IDW-1:0]  id;
    logic [MEM_AW-1:0]   addr;
    logic [AXI_LENW-1:0] len;
    logic [1:0]          burst;
    logic                illegal;
  } cmd_t;
  typedef struct packed {
    logic [AXI_IDW-1:0] id;
    logic [1:0]         resp;
  } brsp_t;
  cmd_t                  cmd_mem_q [CMD_DEPTH];
  brsp_t                 b_mem_q [BRSP_DEPTH];
  logic [CPW:0]          cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [BPW:0]          b_wp_q, b_wp_d, b_rp_q, b_rp_d;
  w_state_e              state_q, state_d;
  logic [AXI_LENW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [MEM_AW-1:0]     cur_addr_q, cur_addr_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]     mem_addr_q, mem_addr_d;
  logic [AXI_DATA_WID-1:0] mem_wdata_q, mem_wdata_d;
  logic [AXI_STRBW-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic                  cmd_full, cmd_empty, b_full, b_empty;
  logic                  aw_hs, w_hs, b_pop, fin, fin_err, beat_err;
  cmd_t                  head;
  brsp_t                 b_head;
  logic                  unused;
  assign unused    = ^{i_awlock, i_awcache, i_awprot, i_awaddr[AXI_ADDR_WID-1:MEM_AW+5], i_awaddr[4:0]};
  assign cmd_empty = cmd_wp_q == cmd_rp_q;
  assign cmd_full  = (cmd_wp_q[CPW] != cmd_rp_q[CPW]) && (cmd_wp_q[CPW-1:0] == cmd_rp_q[CPW-1:0]);
  assign b_empty   = b_wp_q == b_rp_q;
  assign b_full    = (b_wp_q[BPW] != b_rp_q[BPW]) && (b_wp_q[BPW-1:0] == b_rp_q[BPW-1:0]);
  assign head      = cmd_mem_q[cmd_rp_q[CPW-1:0]];
  assign b_head    = b_mem_q[b_rp_q[BPW-1:0]];
  assign o_awready = !cmd_full && !areset;
  assign o_wready  = (state_q != W_IDLE) && !b_full;
  assign o_bvalid  = !b_empty;
  assign o_bid     = b_empty ? '0 : b_head.id;
  assign o_bresp   = b_empty ? 2'b00 : b_head.resp;
  assign o_idle    = cmd_empty && (state_q == W_IDLE) && b_empty;
  assign o_err_cnt = err_cnt_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;
  assign aw_hs     = i_awvalid && o_awready;
  assign w_hs      = i_wvalid && o_wready;
  assign b_pop     = o_bvalid && i_bready;
  // a wid mismatch poisons this beat and everything after it in the burst
  assign beat_err  = err_q || (i_wid != head.id);
  // W burst tracking, memory write generation and burst-end bookkeeping
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    cur_addr_d  = cur_addr_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    fin         = 1'b0;
    fin_err     = 1'b0;
    if (state_q == W_IDLE && !cmd_empty) begin
      state_d    = W_DATA;
      beat_cnt_d = '0;
      cur_addr_d = head.addr;
      err_d      = head.illegal;
    end
    if (state_q == W_DATA && w_hs) begin
      mem_we_d    = !beat_err;
      mem_addr_d  = beat_err ? mem_addr_q : cur_addr_q;
      mem_wdata_d = beat_err ? mem_wdata_q : i_wdata;
      mem_wstrb_d = beat_err ? mem_wstrb_q : i_wstrb;
      beat_cnt_d  = beat_cnt_q + AXI_LENW'(1);
      cur_addr_d  = head.burst[0] ? cur_addr_q + MEM_AW'(1) : cur_addr_q;
      err_d       = beat_err;
      fin         = i_wlast;
      fin_err     = beat_err || (beat_cnt_q < head.len);
      err_d       = (!i_wlast && beat_cnt_q == head.len) ? 1'b1 : err_d;
      state_d     = (!i_wlast && beat_cnt_q == head.len) ? W_DRAIN : state_d;
    end
    if (state_q == W_DRAIN && w_hs && i_wlast) begin
      fin     = 1'b1;
      fin_err = 1'b1;
    end
    state_d   = fin ? W_IDLE : state_d;
    err_cnt_d = (fin && fin_err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    cmd_wp_d  = aw_hs ? cmd_wp_q + (CPW+1)'(1) : cmd_wp_q;
    cmd_rp_d  = fin ? cmd_rp_q + (CPW+1)'(1) : cmd_rp_q;
    b_wp_d    = fin ? b_wp_q + (BPW+1)'(1) : b_wp_q;
    b_rp_d    = b_pop ? b_rp_q + (BPW+1)'(1) : b_rp_q;
  end
  // queue storage; entries are only read once their pointer marks them valid
  always_ff @(posedge aclk) begin
    if (aw_hs) cmd_mem_q[cmd_wp_q[CPW-1:0]] <= '{i_awid, i_awaddr[MEM_AW+4:5], i_awlen, i_awburst, (i_awsize != 3'd5) || i_awburst[1]};
    if (fin) b_mem_q[b_wp_q[BPW-1:0]] <= '{head.id, fin_err ? 2'b10 : 2'b00};
  end
  // control state, pointers, counters and the registered memory port
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= W_IDLE;
      beat_cnt_q  <= '0;
      cur_addr_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      cmd_wp_q    <= '0;
      cmd_rp_q    <= '0;
      b_wp_q      <= '0;
      b_rp_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      cur_addr_q  <= cur_addr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      cmd_wp_q    <= cmd_wp_d;
      cmd_rp_q    <= cmd_rp_d;
      b_wp_q      <= b_wp_d;
      b_rp_q      <= b_rp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end
endmodule

// File: tb/tb_idma_axi_wr_slave.sv
// tb_idma_axi_wr_slave: scoreboard bench for the AXI write responder
module tb_idma_axi_wr_slave;
  logic aclk = 1'b0, areset = 1'b1;
  logic i_awvalid = 0, o_awready;
  logic [3:0] i_awid = 0;
  logic [31:0] i_awaddr = 0;
  logic [3:0] i_awlen = 0;
  logic [2:0] i_awsize = 3'd5;
  logic [1:0] i_awburst = 2'b01;
  logic i_wvalid = 0, o_wready;
  logic [3:0] i_wid = 0;
  logic i_wlast = 0;
  logic [255:0] i_wdata = 0;
  logic [31:0] i_wstrb = 0;
  logic o_bvalid, i_bready = 1'b1;
  logic [3:0] o_bid;
  logic [1:0] o_bresp;
  logic o_mem_we;
  logic [11:0] o_mem_addr;
  logic [255:0] o_mem_wdata;
  logic [31:0] o_mem_wstrb;
  logic o_idle;
  logic [7:0] o_err_cnt;
  logic [299:0] exp_mem [$];
  logic [5:0] exp_b [$];
  int pass = 0, total = 0, m_pass = 0, m_total = 0;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  always #5 aclk = ~aclk;

  idma_axi_wr_slave dut (
    .aclk(aclk), .areset(areset),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid), .i_awaddr(i_awaddr),
    .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst), .i_awlock(2'b00),
    .i_awcache(4'h0), .i_awprot(3'h0),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wid(i_wid), .i_wlast(i_wlast),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wstrb(o_mem_wstrb), .o_idle(o_idle), .o_err_cnt(o_err_cnt)
  );

  function automatic logic [255:0] dat(input int k);
    return {8{32'hA500_0000 | 32'(k)}};
  endfunction

  task automatic chk(input string nm, input logic [299:0] got, input logic [299:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  // monitor: pops expectations whenever the DUT presents a write or a B handshake
  initial forever begin
    @(negedge aclk);
    if (o_mem_we) begin
      m_total++;
      if (exp_mem.size() == 0) $display("FAIL mem_unexpected got addr=%0h", o_mem_addr);
      else begin
        logic [299:0] e;
        e = exp_mem.pop_front();
        if ({o_mem_addr, o_mem_wdata, o_mem_wstrb} === e) m_pass++;
        else $display("FAIL mem_write got=%0h exp=%0h", {o_mem_addr, o_mem_wdata, o_mem_wstrb}, e);
      end
    end
    if (o_bvalid && i_bready) begin
      m_total++;
      if (exp_b.size() == 0) $display("FAIL b_unexpected got id=%0h resp=%0h", o_bid, o_bresp);
      else begin
        logic [5:0] e;
        e = exp_b.pop_front();
        if ({o_bid, o_bresp} === e) m_pass++;
        else $display("FAIL b_resp got=%0h exp=%0h", {o_bid, o_bresp}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    i_awvalid = 1; i_awid = id; i_awaddr = addr; i_awlen = len; i_awburst = burst; i_awsize = size;
    @(negedge aclk);
    while (!o_awready && n < 200) begin n++; @(negedge aclk); end
    if (!o_awready) chk("aw_timeout", 0, 1);
    @(posedge aclk); #1 i_awvalid = 0;
  endtask

  task automatic send_w(input logic [3:0] id, input int k, input logic [31:0] strb, input logic last,
                        input logic wr, input logic [11:0] addr);
    int n = 0;
    if (wr) exp_mem.push_back({addr, dat(k), strb});
    i_wvalid = 1; i_wid = id; i_wdata = dat(k); i_wstrb = strb; i_wlast = last;
    @(negedge aclk);
    while (!o_wready && n < 200) begin n++; @(negedge aclk); end
    if (!o_wready) chk("w_timeout", 0, 1);
    @(posedge aclk); #1 i_wvalid = 0; i_wlast = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_mem.size() != 0 || exp_b.size() != 0 || !o_idle) && n < 300) begin n++; @(posedge aclk); #1; end
    chk(nm, {exp_mem.size() == 0, exp_b.size() == 0, o_idle}, 3'b111);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", o_awready, 0);
    chk("rst_outputs", {o_wready, o_bvalid, o_mem_we, o_bid, o_bresp, o_mem_addr, o_mem_wstrb, o_err_cnt, o_idle}, 1);
    chk("rst_wdata", o_mem_wdata, 0);
    areset = 0;
    @(posedge aclk); #1;
    chk("awready_after_rst", o_awready, 1);
    // INCR baseline
    send_aw(4'd3, 32'h1000, 4'd3, 2'b01, 3'd5);
    for (int b = 0; b < 4; b++) send_w(4'd3, b, ONES, b == 3, 1, 12'h080 + 12'(b));
    exp_b.push_back({4'd3, 2'b00});
    wait_idle("incr_done");
    // FIXED then INCR wrapping at the top of memory
    send_aw(4'd1, 32'h1FFE0, 4'd1, 2'b00, 3'd5);
    send_aw(4'd2, 32'h1FFE0, 4'd1, 2'b01, 3'd5);
    send_w(4'd1, 10, 32'h0000_FFFF, 0, 1, 12'hFFF);
    send_w(4'd1, 11, ONES, 1, 1, 12'hFFF);
    exp_b.push_back({4'd1, 2'b00});
    send_w(4'd2, 12, ONES, 0, 1, 12'hFFF);
    send_w(4'd2, 13, 32'hF0F0_F0F0, 1, 1, 12'h000);
    exp_b.push_back({4'd2, 2'b00});
    wait_idle("fixed_wrap_done");
    chk("err_cnt_0", o_err_cnt, 0);
    // early wlast: two writes, then error response
    send_aw(4'd5, 32'h40, 4'd3, 2'b01, 3'd5);
    send_w(4'd5, 20, ONES, 0, 1, 12'h002);
    send_w(4'd5, 21, ONES, 1, 1, 12'h003);
    exp_b.push_back({4'd5, 2'b10});
    wait_idle("early_done");
    chk("err_cnt_1", o_err_cnt, 1);
    send_aw(4'd6, 32'h80, 4'd0, 2'b01, 3'd5);
    send_w(4'd6, 22, ONES, 1, 1, 12'h004);
    exp_b.push_back({4'd6, 2'b00});
    wait_idle("after_early_done");
    // missing wlast: two writes, two drained
    send_aw(4'd7, 32'hA0, 4'd1, 2'b01, 3'd5);
    send_w(4'd7, 30, ONES, 0, 1, 12'h005);
    send_w(4'd7, 31, ONES, 0, 1, 12'h006);
    send_w(4'd7, 32, ONES, 0, 0, 12'h0);
    send_w(4'd7, 33, ONES, 1, 0, 12'h0);
    exp_b.push_back({4'd7, 2'b10});
    wait_idle("missing_done");
    // wid mismatch on the first beat suppresses the whole burst
    send_aw(4'd8, 32'hC0, 4'd1, 2'b01, 3'd5);
    send_w(4'd9, 40, ONES, 0, 0, 12'h0);
    send_w(4'd8, 41, ONES, 1, 0, 12'h0);
    exp_b.push_back({4'd8, 2'b10});
    wait_idle("badid_done");
    chk("err_cnt_3", o_err_cnt, 3);
    // backpressure: command queue fill, then B queue fill
    i_bready = 0;
    for (int i = 0; i < 4; i++) send_aw(4'(i), 32'h2000 + 32'(i * 32), 4'd0, 2'b01, 3'd5);
    i_awvalid = 1; i_awid = 4'd4; i_awaddr = 32'h2080; i_awlen = 0; i_awburst = 2'b01;
    @(negedge aclk);
    chk("awready_full", o_awready, 0);
    @(posedge aclk); #1 i_awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      send_w(4'(i), 50 + i, ONES, 1, 1, 12'h100 + 12'(i));
      exp_b.push_back({4'(i), 2'b00});
    end
    send_aw(4'd4, 32'h2080, 4'd0, 2'b01, 3'd5);
    repeat (4) @(negedge aclk);
    chk("wready_b_full", o_wready, 0);
    chk("bvalid_held", {o_bvalid, o_bid}, {1'b1, 4'd0});
    @(posedge aclk); #1 i_bready = 1;
    send_w(4'd4, 60, ONES, 1, 1, 12'h104);
    exp_b.push_back({4'd4, 2'b00});
    wait_idle("backpressure_done");
    // reset mid-burst
    send_aw(4'd10, 32'h200, 4'd3, 2'b01, 3'd5);
    send_w(4'd10, 70, ONES, 0, 1, 12'h010);
    send_w(4'd10, 71, ONES, 0, 1, 12'h011);
    areset = 1;
    @(posedge aclk); #1;
    chk("midrst_state", {o_idle, o_bvalid, o_err_cnt, o_awready}, {1'b1, 1'b0, 8'd0, 1'b0});
    areset = 0;
    @(posedge aclk); #1;
    send_aw(4'd11, 32'h300, 4'd1, 2'b01, 3'd5);
    send_w(4'd11, 80, ONES, 0, 1, 12'h018);
    send_w(4'd11, 81, ONES, 1, 1, 12'h019);
    exp_b.push_back({4'd11, 2'b00});
    wait_idle("post_rst_done");
    // illegal awsize
    send_aw(4'd12, 32'h400, 4'd0, 2'b01, 3'd4);
    send_w(4'd12, 90, ONES, 1, 0, 12'h0);
    exp_b.push_back({4'd12, 2'b10});
    wait_idle("illegal_done");
    chk("err_cnt_final", o_err_cnt, 1);
    repeat (3) @(posedge aclk);
    $display("%0d/%0d checks passed", pass + m_pass, total + m_total);
    $finish;
  end
endmodule
